// File: rtl/avalon_dma_master.sv
// Avalon-MM master self-test engine: COPY, FILL and CHECK over a word-addressed slave.
// One command at a time; every output is registered.
module avalon_dma_master #(
    parameter int unsigned ADW = 32,
    parameter int unsigned ASZ = 1024,
    parameter int unsigned ABW = ADW / 8,
    parameter int unsigned AAW = $clog2(ASZ / ABW)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_start,
    input  logic [1:0]     cmd_mode,
    input  logic [AAW-1:0] cmd_src,
    input  logic [AAW-1:0] cmd_dst,
    input  logic [AAW:0]   cmd_len,
    input  logic [ADW-1:0] cmd_pattern,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [AAW:0]   err_cnt,
    output logic [AAW-1:0] first_err_adr,
    output logic           read,
    output logic           write,
    output logic [AAW-1:0] address,
    output logic [ABW-1:0] byteenable,
    output logic [ADW-1:0] writedata,
    input  logic [ADW-1:0] readdata,
    input  logic           waitrequest
);

    localparam int unsigned LW = AAW + 1;
    localparam logic [1:0] MODE_COPY  = 2'b00;
    localparam logic [1:0] MODE_FILL  = 2'b01;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    state_t         state_q, state_d;
    logic [1:0]     mode_q, mode_d;
    logic [AAW-1:0] src_q, src_d, dst_q, dst_d;
    logic [LW-1:0]  len_q, len_d, idx_q, idx_d;
    logic [ADW-1:0] pat_q, pat_d;
    logic           busy_d, done_d, err_d, read_d, write_d;
    logic [LW-1:0]  err_cnt_d, cnt_nxt;
    logic [AAW-1:0] first_err_adr_d, address_d;
    logic [ADW-1:0] writedata_d;

    logic [LW-1:0]  nxt_idx;
    logic           last, xfer, mismatch;

    assign nxt_idx  = idx_q + LW'(1);
    assign last     = (nxt_idx == len_q);
    assign xfer     = (read | write) & ~waitrequest;
    assign mismatch = (readdata != ADW'(pat_q + ADW'(idx_q)));

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= IDLE;
            mode_q        <= MODE_COPY;
            src_q         <= '0;
            dst_q         <= '0;
            len_q         <= '0;
            pat_q         <= '0;
            idx_q         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
            err_cnt       <= '0;
            first_err_adr <= '0;
            read          <= 1'b0;
            write         <= 1'b0;
            address       <= '0;
            writedata     <= '0;
            byteenable    <= '1;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            src_q         <= src_d;
            dst_q         <= dst_d;
            len_q         <= len_d;
            pat_q         <= pat_d;
            idx_q         <= idx_d;
            busy          <= busy_d;
            done          <= done_d;
            err           <= err_d;
            err_cnt       <= err_cnt_d;
            first_err_adr <= first_err_adr_d;
            read          <= read_d;
            write         <= write_d;
            address       <= address_d;
            writedata     <= writedata_d;
            byteenable    <= '1;
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d         = state_q;
        mode_d          = mode_q;
        src_d           = src_q;
        dst_d           = dst_q;
        len_d           = len_q;
        pat_d           = pat_q;
        idx_d           = idx_q;
        busy_d          = busy;
        done_d          = 1'b0;
        err_d           = err;
        err_cnt_d       = err_cnt;
        first_err_adr_d = first_err_adr;
        read_d          = read;
        write_d         = write;
        address_d       = address;
        writedata_d     = writedata;
        cnt_nxt         = err_cnt;

        case (state_q)
            IDLE: begin
                if (cmd_start) begin
                    mode_d          = cmd_mode;
                    src_d           = cmd_src;
                    dst_d           = cmd_dst;
                    len_d           = cmd_len;
                    pat_d           = cmd_pattern;
                    idx_d           = '0;
                    err_d           = (cmd_mode == MODE_RSVD);
                    err_cnt_d       = '0;
                    first_err_adr_d = '0;
                    if (cmd_len == '0 || cmd_mode == MODE_RSVD) begin
                        done_d = 1'b1;
                    end else if (cmd_mode == MODE_FILL) begin
                        state_d     = WR;
                        busy_d      = 1'b1;
                        write_d     = 1'b1;
                        address_d   = cmd_dst;
                        writedata_d = cmd_pattern;
                    end else begin
                        state_d   = RD;
                        busy_d    = 1'b1;
                        read_d    = 1'b1;
                        address_d = cmd_src;
                    end
                end
            end
            RD: begin
                if (xfer) begin
                    if (mode_q == MODE_COPY) begin
                        // Read word goes straight out as the next write
                        state_d     = WR;
                        read_d      = 1'b0;
                        write_d     = 1'b1;
                        address_d   = AAW'(dst_q + AAW'(idx_q));
                        writedata_d = readdata;
                    end else begin
                        if (mismatch && err_cnt != '1) begin
                            cnt_nxt = err_cnt + LW'(1);
                        end
                        if (mismatch && err_cnt == '0) begin
                            first_err_adr_d = address;
                        end
                        err_cnt_d = cnt_nxt;
                        if (last) begin
                            state_d = IDLE;
                            read_d  = 1'b0;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            err_d   = (cnt_nxt != '0);
                        end else begin
                            idx_d     = nxt_idx;
                            address_d = AAW'(src_q + AAW'(nxt_idx));
                        end
                    end
                end
            end
            WR: begin
                if (xfer) begin
                    if (last) begin
                        state_d = IDLE;
                        write_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = nxt_idx;
                        if (mode_q == MODE_COPY) begin
                            state_d   = RD;
                            write_d   = 1'b0;
                            read_d    = 1'b1;
                            address_d = AAW'(src_q + AAW'(nxt_idx));
                        end else begin
                            address_d   = AAW'(dst_q + AAW'(nxt_idx));
                            writedata_d = ADW'(pat_q + ADW'(nxt_idx));
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
